video2axis_sof_packer: RTL and testbench
========================================

// Module: video2axis_sof_packer
// PURPOSE
//  Converts a free-running parallel video stream (data/en/hs/vs) into AXI4-Stream video: tuser on the first
//  pixel of a frame, tlast on the last pixel of each line. Single clock; a small internal FWFT FIFO absorbs
//  sink backpressure because the video side cannot stall. Sits upstream of axis2video_vtc_freerun /
//  VDMA write. Reports frame lock, overflow and measured frame size.
// PARAMETERS
//  DATA_WIDTH  16    pixel width
//  FIFO_DEEP   512   FIFO depth in entries; power of 2, >=4
// PORTS
//  rst_n          in   1            asynchronous, active-low reset
//  clk            in   1            single clock for video input and AXIS output
//  enable         in   1            1 = capture frames; sampled only at frame start
//  ACTIVE_WIDTH   in   16           expected pixels per line
//  ACTIVE_HEIGHT  in   16           expected lines per frame
//  din            in   DATA_WIDTH   pixel data, valid when en_in=1
//  en_in          in   1            data enable
//  hs_in          in   1            hsync; pass-through only, not used for framing
//  vs_in          in   1            vsync, active high; rising edge = frame start
//  m_axis_tdata   out  DATA_WIDTH   pixel
//  m_axis_tuser   out  1            start of frame
//  m_axis_tlast   out  1            end of line
//  m_axis_tvalid  out  1            = FIFO not empty
//  m_axis_tready  in   1            sink ready
//  frame_lock     out  1            1 while in ST_RUN
//  overflow       out  1            1-clk pulse, a pixel was dropped because the FIFO was full
//  size_err       out  1            1-clk pulse on line- or frame-size mismatch
//  meas_width     out  16           last measured line length
//  meas_height    out  16           last measured frame line count
//  fifo_count     out  $clog2(FIFO_DEEP)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state ST_IDLE, sof_pending 0, counters 0. Reset is asynchronous and
//   active-low, on rst_n.
//  Input register: din/en_in/vs_in registered once (r_*). vs_rise = r_vs & !r_vs_d.
//  Look-ahead stage: p holds one pixel {data, sof}. p_valid <= r_en.
//   When p_valid=1 it is pushed with last = !r_en, so a line ends on the cycle en_in falls.
//   When r_en loads p and sof_pending=1, p.sof=1 and sof_pending clears.
//  Latency: pixel sampled at edge N is written at edge N+2 and is visible on m_axis at N+2 (FWFT) when the
//   FIFO was empty.
//  FIFO: FWFT, single clock. Push and pop in the same cycle are allowed, including when full.
//   Pop = tvalid & tready. tdata/tuser/tlast are held stable while tvalid & !tready.
//  FSM:
//   ST_IDLE: pushes suppressed; frame_lock=0. On vs_rise & enable -> ST_RUN, sof_pending=1, line/pixel
//    counters cleared.
//   ST_RUN: pushes enabled; frame_lock=1. Push while full (and no pop) -> pixel dropped, overflow=1,
//    -> ST_DROP. On vs_rise & !enable -> ST_IDLE. On vs_rise & enable -> stays in ST_RUN with
//    sof_pending=1. A line in progress at vs_rise completes normally.
//   ST_DROP: pushes suppressed, including the current stage pixel; frame_lock=0. On vs_rise & enable ->
//    ST_RUN, sof_pending=1; on vs_rise & !enable -> ST_IDLE. The FIFO keeps draining.
//  Measurement (ST_RUN only):
//   pix_cnt increments per pushed pixel. On the tlast push: meas_width <= pix_cnt+1, line_cnt++, pix_cnt <= 0.
//   At vs_rise in ST_RUN, when the prior frame was fully captured: meas_height <= line_cnt, line_cnt <= 0.
//   Counters are 16-bit and saturate at 0xFFFF.
//  size_err: pulses when (pix_cnt+1) != ACTIVE_WIDTH at a tlast push, or line_cnt != ACTIVE_HEIGHT at such a
//   vs_rise. If both occur in the same clk, a single pulse.
//  Simultaneous full-push and pop: no drop. en_in without a preceding vs_rise: ignored in ST_IDLE.
// TESTING
//  1 4x3 frame, tready=1, ACTIVE 4/3: 12 beats, tuser on beat 0 only, tlast on beats 3/7/11,
//    meas_width=4, meas_height=3 at next vs, no size_err.
//  2 tready=0 for 20 clk mid-line, FIFO_DEEP=512: no overflow, data order preserved, tdata held stable while stalled.
//  3 FIFO_DEEP=4, tready=0 for a full 8-pixel line: overflow pulses once, frame_lock=0, no further writes;
//    next vs -> tuser beat, lock=1.
//  4 enable=0 mid-frame: current frame completes with all lines, then ST_IDLE; no beats for the next frame.
//  5 line of 5 pixels with ACTIVE_WIDTH=4: size_err pulse at that tlast, meas_width=5.
//  6 rst_n low mid-line with tvalid=1: tvalid=0 immediately (asynchronous); after release, no beats until
//    vs_rise, and first beat has tuser=1.

Source files
------------

// File: rtl/video2axis_sof_packer.sv
// ----------------------------------------------------------------------------
// video2axis_sof_packer
//
// Packs a free-running parallel video stream (din/en_in/hs_in/vs_in) into
// AXI4-Stream video. tuser marks the first pixel of a frame and tlast marks
// the last pixel of each line. The video side cannot stall, so a first-word-
// fall-through FIFO absorbs sink backpressure. When the FIFO overflows, the
// rest of the frame is discarded and capture resumes at the next frame start.
//
// Ports
//   rst_n, clk            asynchronous active-low reset, single clock
//   enable                capture enable, sampled at frame start (vs rise)
//   ACTIVE_WIDTH/HEIGHT   expected pixels per line / lines per frame
//   din, en_in            pixel data and data enable
//   hs_in                 hsync, not used for framing
//   vs_in                 vsync, active high; rising edge starts a frame
//   m_axis_*              AXI4-Stream master (tvalid = FIFO not empty)
//   frame_lock            high while frames are being captured
//   overflow              1-clk pulse when a pixel was dropped (FIFO full)
//   size_err              1-clk pulse on a line or frame size mismatch
//   meas_width/height     last measured line length / frame line count
//   fifo_count            FIFO occupancy
// ----------------------------------------------------------------------------
module video2axis_sof_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEEP  = 512
) (
    input  logic                        rst_n,
    input  logic                        clk,
    input  logic                        enable,
    input  logic [15:0]                 ACTIVE_WIDTH,
    input  logic [15:0]                 ACTIVE_HEIGHT,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic                        en_in,
    input  logic                        hs_in,
    input  logic                        vs_in,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tuser,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        frame_lock,
    output logic                        overflow,
    output logic                        size_err,
    output logic [15:0]                 meas_width,
    output logic [15:0]                 meas_height,
    output logic [$clog2(FIFO_DEEP):0]  fifo_count
);

    localparam int AW = $clog2(FIFO_DEEP);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t state, state_nxt;

    // hsync carries no framing information here
    logic unused_hs;
    assign unused_hs = hs_in;

    // ------------------------------------------------------------------
    // Input register
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_en;
    logic                  r_vs;
    logic                  r_vs_d;
    logic                  vs_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_din  <= '0;
            r_en   <= 1'b0;
            r_vs   <= 1'b0;
            r_vs_d <= 1'b0;
        end else begin
            r_din  <= din;
            r_en   <= en_in;
            r_vs   <= vs_in;
            r_vs_d <= r_vs;
        end
    end

    assign vs_rise = r_vs & ~r_vs_d;

    // ------------------------------------------------------------------
    // Look-ahead stage: a pixel is held one cycle so that the following
    // enable sample tells whether it was the last pixel of its line.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] p_data;
    logic                  p_sof;
    logic                  p_valid;
    logic                  p_last;
    logic                  sof_pending;

    assign p_last = ~r_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_data      <= '0;
            p_sof       <= 1'b0;
            p_valid     <= 1'b0;
            sof_pending <= 1'b0;
        end else begin
            p_valid <= r_en;
            if (r_en) begin
                p_data <= r_din;
                p_sof  <= sof_pending;
            end
            if (vs_rise && enable) begin
                sof_pending <= 1'b1;
            end else if (r_en) begin
                sof_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // FWFT FIFO. When full, a push is accepted only alongside a pop; the
    // write then lands on the slot being read out in the same edge.
    // ------------------------------------------------------------------
    logic [EW-1:0] mem [FIFO_DEEP];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          in_run;
    logic          push_try;
    logic          push;
    logic          drop;

    assign full     = (fifo_count == CW'(FIFO_DEEP));
    assign empty    = (fifo_count == '0);
    assign pop      = ~empty & m_axis_tready;
    assign in_run   = (state == ST_RUN);
    assign push_try = p_valid & in_run;
    assign push     = push_try & (~full | pop);
    assign drop     = push_try & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {p_data, p_sof, p_last};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign head          = mem[rd_ptr];
    assign m_axis_tvalid = ~empty;
    assign m_axis_tdata  = empty ? '0 : head[EW-1:2];
    assign m_axis_tuser  = ~empty & head[1];
    assign m_axis_tlast  = ~empty & head[0];

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (vs_rise && enable) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (drop) begin
                    state_nxt = ST_DROP;
                end else if (vs_rise && !enable) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (vs_rise) begin
                    state_nxt = enable ? ST_RUN : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign frame_lock = in_run;

    // ------------------------------------------------------------------
    // Size measurement (saturating 16-bit counters)
    // ------------------------------------------------------------------
    logic [15:0] pix_cnt;
    logic [15:0] line_cnt;
    logic [15:0] pix_inc;
    logic [15:0] line_inc;
    logic        tlast_push;
    logic        width_err;
    logic        height_err;

    assign tlast_push = push & p_last;
    assign pix_inc    = (pix_cnt == 16'hFFFF) ? pix_cnt : pix_cnt + 16'd1;
    // A line ending on the same edge as the frame start still belongs to
    // the frame being closed.
    assign line_inc   = (tlast_push && line_cnt != 16'hFFFF) ? line_cnt + 16'd1 : line_cnt;
    assign width_err  = tlast_push & (pix_inc != ACTIVE_WIDTH);
    assign height_err = in_run & vs_rise & (line_inc != ACTIVE_HEIGHT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt     <= '0;
            line_cnt    <= '0;
            meas_width  <= '0;
            meas_height <= '0;
            overflow    <= 1'b0;
            size_err    <= 1'b0;
        end else begin
            overflow <= drop;
            size_err <= width_err | height_err;
            if (push) begin
                if (p_last) begin
                    meas_width <= pix_inc;
                    pix_cnt    <= '0;
                end else begin
                    pix_cnt <= pix_inc;
                end
            end
            if (in_run && vs_rise) begin
                meas_height <= line_inc;
                line_cnt    <= '0;
            end else begin
                line_cnt <= line_inc;
            end
            if (!in_run && vs_rise && enable) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_video2axis_sof_packer.sv
// ----------------------------------------------------------------------------
// Testbench for video2axis_sof_packer. A deep-FIFO instance carries most
// scenarios; a 4-entry instance sharing the video inputs covers overflow.
// Expected beats come from a frame-level model: each pixel sent while the
// last frame start saw enable=1 becomes one beat, tuser on the first pixel
// after that frame start, tlast on the last pixel of its line.
// ----------------------------------------------------------------------------
module tb_video2axis_sof_packer;

    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          enable = 1'b0;
    logic [15:0]   act_w  = 16'd4;
    logic [15:0]   act_h  = 16'd3;
    logic [DW-1:0] din    = '0;
    logic          en_in  = 1'b0;
    logic          hs_in  = 1'b0;
    logic          vs_in  = 1'b0;

    logic [DW-1:0] tdata;
    logic          tuser, tlast, tvalid;
    logic          tready = 1'b1;
    logic          lock, ovf, serr;
    logic [15:0]   mw, mh;
    logic [9:0]    fcnt;

    logic [DW-1:0] s_tdata;
    logic          s_tuser, s_tlast, s_tvalid;
    logic          s_tready = 1'b1;
    logic          s_lock, s_ovf, s_serr;
    logic [15:0]   s_mw, s_mh;
    logic [2:0]    s_fcnt;

    always #5 clk = ~clk;

    video2axis_sof_packer #(.DATA_WIDTH(DW), .FIFO_DEEP(512)) dut (
        .rst_n(rst_n), .clk(clk), .enable(enable),
        .ACTIVE_WIDTH(act_w), .ACTIVE_HEIGHT(act_h),
        .din(din), .en_in(en_in), .hs_in(hs_in), .vs_in(vs_in),
        .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .frame_lock(lock), .overflow(ovf), .size_err(serr),
        .meas_width(mw), .meas_height(mh), .fifo_count(fcnt)
    );

    video2axis_sof_packer #(.DATA_WIDTH(DW), .FIFO_DEEP(4)) dut_s (
        .rst_n(rst_n), .clk(clk), .enable(enable),
        .ACTIVE_WIDTH(act_w), .ACTIVE_HEIGHT(act_h),
        .din(din), .en_in(en_in), .hs_in(hs_in), .vs_in(vs_in),
        .m_axis_tdata(s_tdata), .m_axis_tuser(s_tuser), .m_axis_tlast(s_tlast),
        .m_axis_tvalid(s_tvalid), .m_axis_tready(s_tready),
        .frame_lock(s_lock), .overflow(s_ovf), .size_err(s_serr),
        .meas_width(s_mw), .meas_height(s_mh), .fifo_count(s_fcnt)
    );

    // Beat and pulse collection, sampled mid-cycle
    beat_t obs[$];
    beat_t obs_s[$];
    int    ovf_cnt   = 0;
    int    ovf_cnt_s = 0;
    int    serr_cnt  = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tvalid && tready)     obs.push_back(beat_t'({tdata, tuser, tlast}));
            if (s_tvalid && s_tready) obs_s.push_back(beat_t'({s_tdata, s_tuser, s_tlast}));
            if (ovf)   ovf_cnt++;
            if (s_ovf) ovf_cnt_s++;
            if (serr)  serr_cnt++;
        end
    end

    // Reference model state
    beat_t exp_q[$];
    bit    m_run = 1'b0;
    bit    m_sof = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; en_in = 1'b0; vs_in = 1'b0; hs_in = 1'b0;
        tready = 1'b1; s_tready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        m_run = 1'b0; m_sof = 1'b0;
        exp_q.delete();
    endtask

    task automatic vsync();
        vs_in = 1'b1;
        repeat (2) tick();
        vs_in = 1'b0;
        m_run = enable;
        if (enable) m_sof = 1'b1;
        repeat (4) tick();
    endtask

    task automatic drive_line(input int w);
        for (int i = 0; i < w; i++) begin
            din   = DW'($urandom);
            en_in = 1'b1;
            if (m_run) begin
                exp_q.push_back(beat_t'({din, m_sof, (i == w - 1)}));
                m_sof = 1'b0;
            end
            tick();
        end
        en_in = 1'b0;
        hs_in = 1'b1;
        repeat (2) tick();
        hs_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic drain();
        int n = 0;
        repeat (4) tick();
        while ((tvalid || s_tvalid) && n < 3000) begin
            tick();
            n++;
        end
        n_checks++;
        if (n >= 3000) $display("FAIL drain_timeout: got %0d cycles, required < 3000", n);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({tvalid, tuser, tlast, lock, ovf, serr} !== 6'b0)
            $display("FAIL reset_flags: got %b required 000000", {tvalid, tuser, tlast, lock, ovf, serr});
        else n_pass++;
        apply_reset();
        n_checks++;
        if (tdata !== '0) $display("FAIL reset_tdata: got %h required 0", tdata); else n_pass++;
        n_checks++;
        if (fcnt !== 10'd0) $display("FAIL reset_fifo_count: got %0d required 0", fcnt); else n_pass++;
        n_checks++;
        if (mw !== 16'd0 || mh !== 16'd0) $display("FAIL reset_meas: got %0d/%0d required 0/0", mw, mh); else n_pass++;
        n_checks++;
        if ({tvalid, lock} !== 2'b0) $display("FAIL reset_after_release: got %b required 00", {tvalid, lock}); else n_pass++;
    endtask

    task automatic test_basic_frame();
        int base, se0;
        apply_reset();
        act_w = 16'd4; act_h = 16'd3; enable = 1'b1;
        base = obs.size(); se0 = serr_cnt;
        vsync();
        repeat (3) drive_line(4);
        vsync();
        drain();
        n_checks++;
        if (obs.size() - base !== 12) $display("FAIL t1_beat_count: got %0d required 12", obs.size() - base); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            beat_t got;
            got = 'x;
            if (base + i < obs.size()) got = obs[base + i];
            n_checks++;
            if (got.u !== 1'(i == 0)) $display("FAIL t1_tuser beat %0d: got %b required %b", i, got.u, (i == 0)); else n_pass++;
            n_checks++;
            if (got.l !== 1'(i % 4 == 3)) $display("FAIL t1_tlast beat %0d: got %b required %b", i, got.l, (i % 4 == 3)); else n_pass++;
            n_checks++;
            if (got.d !== exp_q[i].d) $display("FAIL t1_tdata beat %0d: got %h required %h", i, got.d, exp_q[i].d); else n_pass++;
        end
        n_checks++;
        if (mw !== 16'd4) $display("FAIL t1_meas_width: got %0d required 4", mw); else n_pass++;
        n_checks++;
        if (mh !== 16'd3) $display("FAIL t1_meas_height: got %0d required 3", mh); else n_pass++;
        n_checks++;
        if (serr_cnt - se0 !== 0) $display("FAIL t1_size_err: got %0d pulses required 0", serr_cnt - se0); else n_pass++;
        n_checks++;
        if (lock !== 1'b1) $display("FAIL t1_frame_lock: got %b required 1", lock); else n_pass++;
    endtask

    task automatic test_backpressure();
        int base, o0, se0, w;
        apply_reset();
        w = $urandom_range(30, 50);
        act_w = 16'(w); act_h = 16'd2; enable = 1'b1;
        base = obs.size(); o0 = ovf_cnt; se0 = serr_cnt;
        vsync();
        fork
            begin
                repeat (2) drive_line(w);
                vsync();
            end
            begin
                logic [DW-1:0] hold_exp;
                repeat (15) tick();
                tready = 1'b0;
                @(negedge clk);
                hold_exp = exp_q[obs.size() - base].d;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    n_checks++;
                    if (tvalid !== 1'b1 || tdata !== hold_exp)
                        $display("FAIL t2_hold cycle %0d: got valid=%b data=%h required valid=1 data=%h", c, tvalid, tdata, hold_exp);
                    else n_pass++;
                end
                tick();
                tready = 1'b1;
            end
        join
        drain();
        n_checks++;
        if (obs.size() - base !== exp_q.size()) $display("FAIL t2_beat_count: got %0d required %0d", obs.size() - base, exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            beat_t got;
            got = 'x;
            if (base + i < obs.size()) got = obs[base + i];
            n_checks++;
            if (got !== exp_q[i]) $display("FAIL t2_beat %0d: got %h required %h", i, got, exp_q[i]); else n_pass++;
        end
        n_checks++;
        if (ovf_cnt - o0 !== 0) $display("FAIL t2_overflow: got %0d pulses required 0", ovf_cnt - o0); else n_pass++;
        n_checks++;
        if (serr_cnt - se0 !== 0) $display("FAIL t2_size_err: got %0d pulses required 0", serr_cnt - se0); else n_pass++;
        n_checks++;
        if (mh !== 16'd2) $display("FAIL t2_meas_height: got %0d required 2", mh); else n_pass++;
    endtask

    task automatic test_overflow();
        int base, o0;
        apply_reset();
        act_w = 16'd8; act_h = 16'd1; enable = 1'b1;
        s_tready = 1'b0;
        base = obs_s.size(); o0 = ovf_cnt_s;
        vsync();
        drive_line(8);
        n_checks++;
        if (ovf_cnt_s - o0 !== 1) $display("FAIL t3_overflow_pulses: got %0d required 1", ovf_cnt_s - o0); else n_pass++;
        n_checks++;
        if (s_lock !== 1'b0) $display("FAIL t3_lock_after_drop: got %b required 0", s_lock); else n_pass++;
        n_checks++;
        if (s_fcnt !== 3'd4) $display("FAIL t3_fifo_count: got %0d required 4", s_fcnt); else n_pass++;
        s_tready = 1'b1;
        repeat (10) tick();
        n_checks++;
        if (obs_s.size() - base !== 4) $display("FAIL t3_kept_beats: got %0d required 4", obs_s.size() - base); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            beat_t got;
            got = 'x;
            if (base + i < obs_s.size()) got = obs_s[base + i];
            n_checks++;
            if (got !== exp_q[i]) $display("FAIL t3_kept_beat %0d: got %h required %h", i, got, exp_q[i]); else n_pass++;
        end
        vsync();
        n_checks++;
        if (s_lock !== 1'b1) $display("FAIL t3_relock: got %b required 1", s_lock); else n_pass++;
        drive_line(8);
        vsync();
        drain();
        n_checks++;
        if (obs_s.size() - base !== 12) $display("FAIL t3_total_beats: got %0d required 12", obs_s.size() - base); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            beat_t got;
            got = 'x;
            if (base + 4 + i < obs_s.size()) got = obs_s[base + 4 + i];
            n_checks++;
            if (got !== exp_q[8 + i]) $display("FAIL t3_new_frame_beat %0d: got %h required %h", i, got, exp_q[8 + i]); else n_pass++;
        end
        n_checks++;
        if (ovf_cnt_s - o0 !== 1) $display("FAIL t3_overflow_final: got %0d required 1", ovf_cnt_s - o0); else n_pass++;
    endtask

    task automatic test_enable_off();
        int base, se0, w, h;
        apply_reset();
        w = $urandom_range(3, 12);
        h = $urandom_range(2, 5);
        act_w = 16'(w); act_h = 16'(h); enable = 1'b1;
        base = obs.size(); se0 = serr_cnt;
        vsync();
        drive_line(w);
        enable = 1'b0;
        repeat (h - 1) drive_line(w);
        vsync();
        repeat (h) drive_line(w);
        vsync();
        drain();
        n_checks++;
        if (obs.size() - base !== w * h) $display("FAIL t4_beat_count: got %0d required %0d", obs.size() - base, w * h); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            beat_t got;
            got = 'x;
            if (base + i < obs.size()) got = obs[base + i];
            n_checks++;
            if (got !== exp_q[i]) $display("FAIL t4_beat %0d: got %h required %h", i, got, exp_q[i]); else n_pass++;
        end
        n_checks++;
        if (lock !== 1'b0) $display("FAIL t4_frame_lock: got %b required 0", lock); else n_pass++;
        n_checks++;
        if (mh !== 16'(h)) $display("FAIL t4_meas_height: got %0d required %0d", mh, h); else n_pass++;
        n_checks++;
        if (serr_cnt - se0 !== 0) $display("FAIL t4_size_err: got %0d pulses required 0", serr_cnt - se0); else n_pass++;
    endtask

    task automatic test_size_err();
        int base, se0;
        apply_reset();
        act_w = 16'd4; act_h = 16'd3; enable = 1'b1;
        base = obs.size();
        vsync();
        drive_line(4);
        se0 = serr_cnt;
        drive_line(5);
        n_checks++;
        if (serr_cnt - se0 !== 1) $display("FAIL t5_size_err_pulse: got %0d required 1", serr_cnt - se0); else n_pass++;
        n_checks++;
        if (mw !== 16'd5) $display("FAIL t5_meas_width: got %0d required 5", mw); else n_pass++;
        drive_line(4);
        vsync();
        drain();
        n_checks++;
        if (serr_cnt - se0 !== 1) $display("FAIL t5_size_err_total: got %0d required 1", serr_cnt - se0); else n_pass++;
        n_checks++;
        if (mw !== 16'd4 || mh !== 16'd3) $display("FAIL t5_meas_final: got %0d/%0d required 4/3", mw, mh); else n_pass++;
        n_checks++;
        if (obs.size() - base !== 13) $display("FAIL t5_beat_count: got %0d required 13", obs.size() - base); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            beat_t got;
            got = 'x;
            if (base + i < obs.size()) got = obs[base + i];
            n_checks++;
            if (got !== exp_q[i]) $display("FAIL t5_beat %0d: got %h required %h", i, got, exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        int base;
        apply_reset();
        act_w = 16'd10; act_h = 16'd2; enable = 1'b1;
        tready = 1'b0;
        vsync();
        for (int i = 0; i < 5; i++) begin
            din = DW'($urandom); en_in = 1'b1;
            tick();
        end
        n_checks++;
        if (tvalid !== 1'b1) $display("FAIL t6_valid_before_reset: got %b required 1", tvalid); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tvalid !== 1'b0) $display("FAIL t6_valid_in_reset: got %b required 0", tvalid); else n_pass++;
        n_checks++;
        if (lock !== 1'b0 || fcnt !== 10'd0) $display("FAIL t6_state_in_reset: got lock=%b count=%0d required 0/0", lock, fcnt); else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = DW'($urandom);
            tick();
        end
        en_in = 1'b0;
        repeat (5) tick();
        m_run = 1'b0; m_sof = 1'b0;
        exp_q.delete();
        tready = 1'b1;
        base = obs.size();
        drive_line(10);
        repeat (5) tick();
        n_checks++;
        if (obs.size() - base !== 0) $display("FAIL t6_no_beats_before_vs: got %0d required 0", obs.size() - base); else n_pass++;
        vsync();
        repeat (2) drive_line(10);
        vsync();
        drain();
        n_checks++;
        if (obs.size() - base !== 20) $display("FAIL t6_beat_count: got %0d required 20", obs.size() - base); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            beat_t got;
            got = 'x;
            if (base + i < obs.size()) got = obs[base + i];
            n_checks++;
            if (got !== exp_q[i]) $display("FAIL t6_beat %0d: got %h required %h", i, got, exp_q[i]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_overflow();
        test_enable_off();
        test_size_err();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
